// File: rtl/mem_stage_access.sv
// mem_stage_access: RV32I memory-stage load/store sequencer.
// Turns a decoded load/store into a word-aligned data-cache request with byte enables and
// lane-replicated store data, stalls the pipeline until the cache responds, and formats
// returned load data for writeback. TIMEOUT_CYCLES > 0 enables a BUSY-state watchdog.
// Optional macro MISALIGN_TRAP_EN: misaligned half/word accesses trap instead of being
// rounded down to the containing lane.
module mem_stage_access #(
    parameter int unsigned TIMEOUT_CYCLES = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    output logic [31:0] data_mem_address,
    output logic        data_mem_read,
    output logic        data_mem_write,
    output logic [3:0]  data_mem_mbe,
    output logic [31:0] data_mem_wdata,
    input  logic [31:0] data_mem_rdata,
    input  logic        data_mem_resp,
    output logic        stall,
    output logic [31:0] load_data,
    output logic        load_valid,
    output logic        mem_error,
    output logic        misaligned
);

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    state_e      state_q, state_d;
    logic [31:0] cnt_q;
    logic [1:0]  lane_q;
    logic [2:0]  f3_q;

    logic        accept;
    logic        trap;
    logic        expire;
    logic [3:0]  mbe_fmt;
    logic [31:0] wdata_fmt;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_fmt;

    assign accept = (state_q == StIdle) && req_valid && (mem_read || mem_write);

`ifdef MISALIGN_TRAP_EN
    logic is_half;
    logic is_word;
    logic mis_q;

    // Halfword covers sh/lh, plus lhu on the load side only.
    assign is_half = (funct3 == 3'b001) || (!mem_write && funct3 == 3'b101);
    assign is_word = (funct3 == 3'b010);
    assign trap    = accept && ((is_half && addr[0]) || (is_word && (addr[1:0] != 2'b00)));
    assign misaligned = mis_q;

    // Misaligned pulse lands in the DONE cycle that follows the trapped request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mis_q <= 1'b0;
        end else begin
            mis_q <= trap;
        end
    end
`else
    assign trap       = 1'b0;
    assign misaligned = 1'b0;
`endif

    // Watchdog fires on the BUSY cycle whose count would reach the limit without a resp.
    assign expire = (TIMEOUT_CYCLES != 0) && (cnt_q == TIMEOUT_CYCLES - 1);

    // Store byte enables and lane replication; loads always fetch the whole word.
    always_comb begin
        mbe_fmt   = 4'b0000;
        wdata_fmt = 32'h0;
        if (mem_write) begin
            unique case (funct3)
                3'b000: begin
                    mbe_fmt   = 4'b0001 << addr[1:0];
                    wdata_fmt = {4{store_data[7:0]}};
                end
                3'b001: begin
                    mbe_fmt   = 4'b0011 << {addr[1], 1'b0};
                    wdata_fmt = {2{store_data[15:0]}};
                end
                3'b010: begin
                    mbe_fmt   = 4'b1111;
                    wdata_fmt = store_data;
                end
                default: begin
                    mbe_fmt   = 4'b0000;
                    wdata_fmt = store_data;
                end
            endcase
        end else begin
            mbe_fmt = 4'b1111;
        end
    end

    // Extract and extend the addressed lane of the returned word.
    always_comb begin
        byte_sel = data_mem_rdata[8*lane_q +: 8];
        half_sel = lane_q[1] ? data_mem_rdata[31:16] : data_mem_rdata[15:0];
        unique case (f3_q)
            3'b000:  load_fmt = {{24{byte_sel[7]}}, byte_sel};
            3'b100:  load_fmt = {24'h0, byte_sel};
            3'b001:  load_fmt = {{16{half_sel[15]}}, half_sel};
            3'b101:  load_fmt = {16'h0, half_sel};
            default: load_fmt = data_mem_rdata;
        endcase
    end

    // Next-state and stall: pipeline is frozen while accepting and throughout BUSY.
    always_comb begin
        state_d = state_q;
        stall   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    stall   = 1'b1;
                    state_d = trap ? StDone : StBusy;
                end
            end
            StBusy: begin
                stall = 1'b1;
                if (data_mem_resp || expire) begin
                    state_d = StDone;
                end
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Request registers, watchdog counter, load result and completion pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_mem_address <= 32'h0;
            data_mem_read    <= 1'b0;
            data_mem_write   <= 1'b0;
            data_mem_mbe     <= 4'h0;
            data_mem_wdata   <= 32'h0;
            load_data        <= 32'h0;
            load_valid       <= 1'b0;
            mem_error        <= 1'b0;
            cnt_q            <= 32'h0;
            lane_q           <= 2'b00;
            f3_q             <= 3'b000;
        end else begin
            load_valid <= 1'b0;
            mem_error  <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (accept && !trap) begin
                        data_mem_address <= {addr[31:2], 2'b00};
                        // A simultaneous read+write is treated as a store.
                        data_mem_read    <= mem_read && !mem_write;
                        data_mem_write   <= mem_write;
                        data_mem_mbe     <= mbe_fmt;
                        data_mem_wdata   <= wdata_fmt;
                        lane_q           <= addr[1:0];
                        f3_q             <= funct3;
                        cnt_q            <= 32'h0;
                    end
                end
                StBusy: begin
                    if (data_mem_resp) begin
                        data_mem_read  <= 1'b0;
                        data_mem_write <= 1'b0;
                        if (data_mem_read) begin
                            load_data  <= load_fmt;
                            load_valid <= 1'b1;
                        end
                    end else if (expire) begin
                        data_mem_read  <= 1'b0;
                        data_mem_write <= 1'b0;
                        mem_error      <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 32'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage_access.sv
// Directed self-checking bench for mem_stage_access (watchdog limit 4).
module tb_mem_stage_access;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        mem_read = 1'b0;
    logic        mem_write = 1'b0;
    logic [2:0]  funct3 = 3'b000;
    logic [31:0] addr = 32'h0;
    logic [31:0] store_data = 32'h0;
    logic [31:0] data_mem_address;
    logic        data_mem_read;
    logic        data_mem_write;
    logic [3:0]  data_mem_mbe;
    logic [31:0] data_mem_wdata;
    logic [31:0] data_mem_rdata = 32'h0;
    logic        data_mem_resp = 1'b0;
    logic        stall;
    logic [31:0] load_data;
    logic        load_valid;
    logic        mem_error;
    logic        misaligned;

    int checks = 0;
    int errors = 0;

    mem_stage_access #(.TIMEOUT_CYCLES(4)) dut (
        .clk              (clk),
        .rst              (rst),
        .req_valid        (req_valid),
        .mem_read         (mem_read),
        .mem_write        (mem_write),
        .funct3           (funct3),
        .addr             (addr),
        .store_data       (store_data),
        .data_mem_address (data_mem_address),
        .data_mem_read    (data_mem_read),
        .data_mem_write   (data_mem_write),
        .data_mem_mbe     (data_mem_mbe),
        .data_mem_wdata   (data_mem_wdata),
        .data_mem_rdata   (data_mem_rdata),
        .data_mem_resp    (data_mem_resp),
        .stall            (stall),
        .load_data        (load_data),
        .load_valid       (load_valid),
        .mem_error        (mem_error),
        .misaligned       (misaligned)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Sample point is 3 time units after the rising edge.
    task automatic next();
        @(posedge clk);
        #3;
    endtask

    // Present a request for one cycle; returns at the first BUSY (or trap DONE) sample point.
    task automatic issue(input logic rd, input logic wr, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] sd);
        req_valid  = 1'b1;
        mem_read   = rd;
        mem_write  = wr;
        funct3     = f3;
        addr       = a;
        store_data = sd;
        #1;
        check("accept_stall", {31'h0, stall}, 32'h1);
        next();
        req_valid = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        #1;
    endtask

    // Pulse resp in the current BUSY cycle; returns at the DONE sample point.
    task automatic respond(input logic [31:0] rdata);
        data_mem_rdata = rdata;
        data_mem_resp  = 1'b1;
        next();
        data_mem_resp = 1'b0;
        #1;
    endtask

    initial begin
        // Reset state
        #3;
        check("rst_addr", data_mem_address, 32'h0);
        check("rst_ctrl", {26'h0, data_mem_read, data_mem_write, stall, load_valid, mem_error,
                           misaligned}, 32'h0);
        check("rst_mbe", {28'h0, data_mem_mbe}, 32'h0);
        check("rst_wdata", data_mem_wdata, 32'h0);
        check("rst_load_data", load_data, 32'h0);
        next();
        rst = 1'b0;
        next();

        // sw, unaligned low bits ignored, resp in third BUSY cycle: 4 stall cycles
        issue(1'b0, 1'b1, 3'b010, 32'h1000_0006, 32'hDEAD_BEEF);
        check("sw_addr", data_mem_address, 32'h1000_0004);
        check("sw_mbe", {28'h0, data_mem_mbe}, 32'hF);
        check("sw_wdata", data_mem_wdata, 32'hDEAD_BEEF);
        check("sw_strobes", {30'h0, data_mem_write, data_mem_read}, 32'h2);
        check("sw_stall_b1", {31'h0, stall}, 32'h1);
        next();
        check("sw_stall_b2", {31'h0, stall}, 32'h1);
        next();
        check("sw_stall_b3", {31'h0, stall}, 32'h1);
        respond(32'h0);
        check("sw_done", {29'h0, stall, data_mem_write, load_valid}, 32'h0);
        next();

        // sb lane 3
        issue(1'b0, 1'b1, 3'b000, 32'h2000_0003, 32'h0000_00A5);
        check("sb_addr", data_mem_address, 32'h2000_0000);
        check("sb_mbe", {28'h0, data_mem_mbe}, 32'h8);
        check("sb_wdata", data_mem_wdata, 32'hA5A5_A5A5);
        respond(32'h0);
        next();

        // sh upper half with read also set: store wins
        issue(1'b1, 1'b1, 3'b001, 32'h2000_0002, 32'h1234_BEEF);
        check("sh_mbe", {28'h0, data_mem_mbe}, 32'hC);
        check("sh_wdata", data_mem_wdata, 32'hBEEF_BEEF);
        check("sh_rw_strobes", {30'h0, data_mem_write, data_mem_read}, 32'h2);
        respond(32'h0);
        check("sh_no_load_valid", {31'h0, load_valid}, 32'h0);
        next();

        // Illegal store funct3: strobe still issued with empty mask
        issue(1'b0, 1'b1, 3'b011, 32'h2000_0000, 32'h5555_AAAA);
        check("bad_f3_mbe", {28'h0, data_mem_mbe}, 32'h0);
        check("bad_f3_write", {31'h0, data_mem_write}, 32'h1);
        respond(32'h0);
        next();

        // lb lane 2, negative byte
        issue(1'b1, 1'b0, 3'b000, 32'h3000_0002, 32'h0);
        check("lb_addr", data_mem_address, 32'h3000_0000);
        check("lb_mbe", {28'h0, data_mem_mbe}, 32'hF);
        check("lb_read", {30'h0, data_mem_write, data_mem_read}, 32'h1);
        respond(32'h0080_0000);
        check("lb_data", load_data, 32'hFFFF_FF80);
        check("lb_valid", {31'h0, load_valid}, 32'h1);
        check("lb_stall", {31'h0, stall}, 32'h0);
        next();
        check("lb_valid_pulse", {31'h0, load_valid}, 32'h0);
        check("lb_data_hold", load_data, 32'hFFFF_FF80);

        // lbu same address
        issue(1'b1, 1'b0, 3'b100, 32'h3000_0002, 32'h0);
        respond(32'h0080_0000);
        check("lbu_data", load_data, 32'h0000_0080);
        next();

        // lh upper half
        issue(1'b1, 1'b0, 3'b001, 32'h3000_0002, 32'h0);
        respond(32'h8001_0000);
        check("lh_data", load_data, 32'hFFFF_8001);
        next();

        // lhu lower half
        issue(1'b1, 1'b0, 3'b101, 32'h3000_0000, 32'h0);
        respond(32'h1234_8001);
        check("lhu_data", load_data, 32'h0000_8001);
        next();

        // resp while IDLE is ignored
        data_mem_rdata = 32'hFFFF_FFFF;
        data_mem_resp  = 1'b1;
        next();
        data_mem_resp = 1'b0;
        #1;
        check("idle_resp", {30'h0, stall, load_valid}, 32'h0);
        check("idle_resp_data", load_data, 32'h0000_8001);
        next();

        // Watchdog: 4 BUSY cycles without resp
        issue(1'b1, 1'b0, 3'b010, 32'h4000_0000, 32'h0);
        next();
        next();
        next();
        check("wd_b4_read", {30'h0, data_mem_read, stall}, 32'h3);
        check("wd_b4_err", {31'h0, mem_error}, 32'h0);
        next();
        check("wd_done", {28'h0, data_mem_read, mem_error, load_valid, stall}, 32'h4);
        check("wd_load_hold", load_data, 32'h0000_8001);
        // Late resp during DONE must not be taken
        data_mem_rdata = 32'h9999_9999;
        data_mem_resp  = 1'b1;
        next();
        data_mem_resp = 1'b0;
        #1;
        check("wd_late_resp", {29'h0, mem_error, load_valid, stall}, 32'h0);
        check("wd_late_data", load_data, 32'h0000_8001);
        next();

        // resp on the expiry cycle wins
        issue(1'b1, 1'b0, 3'b010, 32'h4000_0010, 32'h0);
        next();
        next();
        next();
        respond(32'h1122_3344);
        check("wd_race_flags", {30'h0, mem_error, load_valid}, 32'h1);
        check("wd_race_data", load_data, 32'h1122_3344);
        next();

        // Asynchronous reset during BUSY
        issue(1'b1, 1'b0, 3'b010, 32'h5000_0004, 32'h0);
        check("pre_rst_read", {31'h0, data_mem_read}, 32'h1);
        rst = 1'b1;
        #1;
        check("arst_ctrl", {29'h0, data_mem_read, stall, load_valid}, 32'h0);
        check("arst_addr", data_mem_address, 32'h0);
        check("arst_mbe", {28'h0, data_mem_mbe}, 32'h0);
        check("arst_load", load_data, 32'h0);
        next();
        rst = 1'b0;
        next();
        issue(1'b1, 1'b0, 3'b010, 32'h6000_0008, 32'h0);
        check("post_rst_addr", data_mem_address, 32'h6000_0008);
        respond(32'hCAFE_F00D);
        check("post_rst_data", load_data, 32'hCAFE_F00D);
        check("post_rst_valid", {31'h0, load_valid}, 32'h1);
        next();

        // Misaligned word load
        issue(1'b1, 1'b0, 3'b010, 32'h7000_0002, 32'h0);
`ifdef MISALIGN_TRAP_EN
        check("mis_flags", {28'h0, data_mem_read, misaligned, load_valid, stall}, 32'h4);
        next();
        check("mis_pulse", {31'h0, misaligned}, 32'h0);
`else
        check("mis_round_addr", data_mem_address, 32'h7000_0000);
        check("mis_round_read", {31'h0, data_mem_read}, 32'h1);
        respond(32'hA1B2_C3D4);
        check("mis_round_data", load_data, 32'hA1B2_C3D4);
        check("mis_tied", {31'h0, misaligned}, 32'h0);
        next();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global time bound so the run always ends.
    initial begin
        #20000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "bench timed out");
    end

endmodule
